// File: rtl/membus_lsu.sv
// Membus load/store initiator: turns RV64 core loads/stores into lane-aligned
// 64-bit bus transactions and returns sign/zero-extended load data.
module membus_lsu #(
    parameter int XLEN              = 64,
    parameter int MEMBUS_DATA_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic                           req_wen,
    input  logic [2:0]                     req_funct3,
    input  logic [XLEN-1:0]                req_addr,
    input  logic [XLEN-1:0]                req_wdata,
    output logic                           busy,
    output logic                           done,
    output logic [XLEN-1:0]                rdata,
    output logic                           err,
    output logic                           membus_valid,
    input  logic                           membus_ready,
    output logic [XLEN-1:0]                membus_addr,
    output logic                           membus_wen,
    output logic [MEMBUS_DATA_WIDTH-1:0]   membus_wdata,
    output logic [MEMBUS_DATA_WIDTH/8-1:0] membus_wmask,
    input  logic                           membus_rvalid,
    input  logic [MEMBUS_DATA_WIDTH-1:0]   membus_rdata
);

    localparam int NB   = MEMBUS_DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_valid;
    logic [XLEN-1:0]          r_addr;
    logic                     r_wen;
    logic [MEMBUS_DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]            r_wmask;
    logic [2:0]               r_funct3;
    logic                     r_done;
    logic                     r_err;
    logic [XLEN-1:0]          r_rdata;

    logic [OFFW-1:0]              w_off;
    logic [NB-1:0]                w_size_mask;
    logic [NB-1:0]                w_wmask;
    logic [MEMBUS_DATA_WIDTH-1:0] w_wdata;
    logic                         w_misaligned;
    logic                         w_illegal;
    logic [MEMBUS_DATA_WIDTH-1:0] w_rshift;
    logic [XLEN-1:0]              w_load_ext;

    assign w_off = req_addr[OFFW-1:0];

    // Access size in bytes is 1 << funct3[1:0]; enable that many low lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_size_mask
            assign w_size_mask[gi] = (gi < (32'd1 << req_funct3[1:0]));
        end
    endgenerate

    assign w_wmask = req_wen ? (w_size_mask << w_off) : '0;
    assign w_wdata = req_wen ? (MEMBUS_DATA_WIDTH'(req_wdata) << {w_off, 3'b000}) : '0;

    always_comb begin
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = w_off[0];
            2'b10:   w_misaligned = |w_off[1:0];
            2'b11:   w_misaligned = |w_off;
            default: w_misaligned = 1'b0;
        endcase
    end

    // Unsigned variants have no store counterpart.
    assign w_illegal = (req_funct3 == 3'b111) || (req_wen && req_funct3[2]);

    assign w_rshift = membus_rdata >> {r_addr[OFFW-1:0], 3'b000};

    always_comb begin
        w_load_ext = XLEN'(w_rshift);
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_rshift[7]}},   w_rshift[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            3'b010:  w_load_ext = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}},  w_rshift[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            3'b110:  w_load_ext = {{(XLEN-32){1'b0}}, w_rshift[31:0]};
            default: w_load_ext = XLEN'(w_rshift);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_funct3 <= 3'b000;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The cycle showing done/err is the core's retire slot: no new accept.
                    if (req_valid && !r_done && !r_err) begin
                        if (w_misaligned || w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr   <= req_addr;
                            r_wen    <= req_wen;
                            r_funct3 <= req_funct3;
                            r_wdata  <= w_wdata;
                            r_wmask  <= w_wmask;
                            r_valid  <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (membus_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (membus_rvalid) begin
                        if (!r_wen) begin
                            r_rdata <= w_load_ext;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = req_valid && !(r_done || r_err);
    assign done         = r_done;
    assign err          = r_err;
    assign rdata        = r_rdata;
    assign membus_valid = r_valid;
    assign membus_addr  = r_addr;
    assign membus_wen   = r_wen;
    assign membus_wdata = r_wdata;
    assign membus_wmask = r_wmask;

endmodule

// File: tb/tb_membus_lsu.sv
// Directed bench for membus_lsu: a cycle-stepped responder inside each access
// task, with hand-computed lane, mask and extension results.
`timescale 1ns/1ps
module tb_membus_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        busy, done, err;
    logic [63:0] rdata;
    logic        membus_valid;
    logic        membus_ready = 1'b0;
    logic [63:0] membus_addr;
    logic        membus_wen;
    logic [63:0] membus_wdata;
    logic [7:0]  membus_wmask;
    logic        membus_rvalid = 1'b0;
    logic [63:0] membus_rdata = '0;

    membus_lsu #(.XLEN(64), .MEMBUS_DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .membus_valid(membus_valid), .membus_ready(membus_ready),
        .membus_addr(membus_addr), .membus_wen(membus_wen),
        .membus_wdata(membus_wdata), .membus_wmask(membus_wmask),
        .membus_rvalid(membus_rvalid), .membus_rdata(membus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [63:0] RSP = 64'h89AB_CDEF_0123_4567;

    // Results of the most recent do_access call.
    int          t_done_cyc, t_err_cyc, t_accepts, t_valid_cnt, t_done_pulses, t_err_pulses;
    logic [63:0] t_addr, t_wdata, t_rdata;
    logic [7:0]  t_wmask;
    logic        t_wen, t_busy1;
    bit          t_stable;

    task automatic do_access(input logic [2:0] f3, input logic wen, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] rsp,
                             input int stall, input bit drop_req);
        bit pend = 0;
        bit seen = 0;
        t_done_cyc = -1; t_err_cyc = -1; t_accepts = 0; t_valid_cnt = 0;
        t_done_pulses = 0; t_err_pulses = 0; t_stable = 1; t_busy1 = 0;
        t_addr = '0; t_wdata = '0; t_rdata = '0; t_wmask = '0; t_wen = 0;
        @(negedge clk);
        req_valid = 1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        membus_ready = 0; membus_rvalid = 0; membus_rdata = rsp;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) t_busy1 = busy;
            membus_rvalid = pend; pend = 0; membus_ready = 0;
            if (drop_req && c == 2) req_valid = 0;
            if (membus_valid) begin
                if (!seen) begin
                    t_addr = membus_addr; t_wdata = membus_wdata;
                    t_wmask = membus_wmask; t_wen = membus_wen; seen = 1;
                end else if (membus_addr !== t_addr || membus_wdata !== t_wdata ||
                             membus_wmask !== t_wmask || membus_wen !== t_wen) begin
                    t_stable = 0;
                end
                if (t_valid_cnt >= stall) begin
                    membus_ready = 1; t_accepts++; pend = 1;
                end
                t_valid_cnt++;
            end
            if (done) begin t_done_pulses++; t_done_cyc = c; t_rdata = rdata; end
            if (err) begin t_err_pulses++; t_err_cyc = c; end
            if (done || err) break;
        end
        req_valid = 0; membus_ready = 0; membus_rvalid = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) t_done_pulses++;
            if (err) t_err_pulses++;
            if (membus_valid) t_valid_cnt++;
        end
        $display("txn f3=%0d wen=%0d addr=%h wdata=%h -> done@%0d err@%0d rdata=%h wmask=%h",
                 f3, wen, addr, wdata, t_done_cyc, t_err_cyc, t_rdata, t_wmask);
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (membus_valid !== 1'b0 || membus_wen !== 1'b0) $display("FAIL reset_valid_wen: got %b%b expected 00", membus_valid, membus_wen); else n_pass++;
        n_checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) $display("FAIL reset_done_err_busy: got %b%b%b expected 000", done, err, busy); else n_pass++;
        n_checks++; if (membus_addr !== 64'h0 || membus_wdata !== 64'h0 || membus_wmask !== 8'h0) $display("FAIL reset_bus_regs: got %h %h %h expected zeros", membus_addr, membus_wdata, membus_wmask); else n_pass++;
        n_checks++; if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        do_access(3'b010, 1'b0, 64'h1004, 64'h0, RSP, 0, 0);
        n_checks++; if (t_addr !== 64'h1004) $display("FAIL lw_addr: got %h expected 1004", t_addr); else n_pass++;
        n_checks++; if (t_wmask !== 8'h00 || t_wen !== 1'b0) $display("FAIL lw_mask_wen: got %h %b expected 00 0", t_wmask, t_wen); else n_pass++;
        n_checks++; if (t_rdata !== 64'hFFFF_FFFF_89AB_CDEF) $display("FAIL lw_rdata: got %h expected ffffffff89abcdef", t_rdata); else n_pass++;
        n_checks++; if (t_done_cyc !== 3) $display("FAIL lw_latency: got %0d expected 3", t_done_cyc); else n_pass++;
        n_checks++; if (t_busy1 !== 1'b1) $display("FAIL lw_busy: got %b expected 1", t_busy1); else n_pass++;
        n_checks++; if (t_done_pulses !== 1 || t_accepts !== 1) $display("FAIL lw_pulses: got done=%0d acc=%0d expected 1 1", t_done_pulses, t_accepts); else n_pass++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [8] = '{3'b100, 3'b000, 3'b001, 3'b101, 3'b110, 3'b011, 3'b000, 3'b001};
        logic [63:0] adrs [8] = '{64'h1003, 64'h1007, 64'h1006, 64'h1006, 64'h1004, 64'h1000, 64'h1000, 64'h1002};
        logic [63:0] exps [8] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FF89,
                                  64'hFFFF_FFFF_FFFF_89AB, 64'h0000_0000_0000_89AB,
                                  64'h0000_0000_89AB_CDEF, 64'h89AB_CDEF_0123_4567,
                                  64'h0000_0000_0000_0067, 64'h0000_0000_0000_0123};
        for (int i = 0; i < 8; i++) begin
            do_access(f3s[i], 1'b0, adrs[i], 64'h0, RSP, 0, 0);
            n_checks++; if (t_rdata !== exps[i] || t_done_cyc !== 3) $display("FAIL load_%0d: got %h@%0d expected %h@3", i, t_rdata, t_done_cyc, exps[i]); else n_pass++;
        end
    endtask

    task automatic test_store_sh();
        do_access(3'b001, 1'b1, 64'h2006, 64'hDEAD_1234, 64'h0, 0, 0);
        n_checks++; if (t_wdata !== 64'h1234_0000_0000_0000) $display("FAIL sh_wdata: got %h expected 1234000000000000", t_wdata); else n_pass++;
        n_checks++; if (t_wmask !== 8'hC0 || t_wen !== 1'b1) $display("FAIL sh_mask_wen: got %h %b expected c0 1", t_wmask, t_wen); else n_pass++;
        n_checks++; if (t_addr !== 64'h2006 || t_done_cyc !== 3) $display("FAIL sh_addr_done: got %h@%0d expected 2006@3", t_addr, t_done_cyc); else n_pass++;
    endtask

    task automatic test_errors();
        logic [2:0]  f3s  [5] = '{3'b010, 3'b011, 3'b001, 3'b111, 3'b100};
        logic        wens [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] adrs [5] = '{64'h1002, 64'h2004, 64'h1001, 64'h1000, 64'h1000};
        for (int i = 0; i < 5; i++) begin
            do_access(f3s[i], wens[i], adrs[i], 64'h55, RSP, 0, 0);
            n_checks++; if (t_err_cyc !== 1 || t_err_pulses !== 1) $display("FAIL err_%0d_pulse: got cyc=%0d n=%0d expected 1 1", i, t_err_cyc, t_err_pulses); else n_pass++;
            n_checks++; if (t_valid_cnt !== 0 || t_done_pulses !== 0) $display("FAIL err_%0d_nobus: got valid=%0d done=%0d expected 0 0", i, t_valid_cnt, t_done_pulses); else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_access(3'b011, 1'b1, 64'h3000, 64'h0123_4567_89AB_CDEF, 64'h0, 3, 0);
        n_checks++; if (t_stable !== 1'b1 || t_valid_cnt !== 4) $display("FAIL stall_stable: got stable=%0d valid=%0d expected 1 4", t_stable, t_valid_cnt); else n_pass++;
        n_checks++; if (t_wmask !== 8'hFF || t_wdata !== 64'h0123_4567_89AB_CDEF || t_addr !== 64'h3000) $display("FAIL stall_bus: got %h %h %h expected ff 0123456789abcdef 3000", t_wmask, t_wdata, t_addr); else n_pass++;
        n_checks++; if (t_accepts !== 1 || t_done_pulses !== 1 || t_done_cyc !== 6) $display("FAIL stall_done: got acc=%0d done=%0d@%0d expected 1 1@6", t_accepts, t_done_pulses, t_done_cyc); else n_pass++;
    endtask

    task automatic test_req_drop();
        do_access(3'b000, 1'b0, 64'h1004, 64'h0, RSP, 0, 1);
        n_checks++; if (t_done_cyc !== 3 || t_rdata !== 64'hFFFF_FFFF_FFFF_FFEF) $display("FAIL drop_done: got %h@%0d expected ffffffffffffffef@3", t_rdata, t_done_cyc); else n_pass++;
    endtask

    task automatic test_stray_rvalid();
        @(negedge clk);
        membus_rvalid = 1; membus_rdata = RSP;
        @(negedge clk);
        membus_rvalid = 0;
        n_checks++; if (done !== 1'b0 || membus_valid !== 1'b0) $display("FAIL stray_idle: got done=%b valid=%b expected 0 0", done, membus_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_funct3 = 3'b100; req_addr = 64'h1003; membus_rdata = RSP;
        @(negedge clk); membus_ready = 1;                 // cycle 1: ISSUE
        @(negedge clk); membus_ready = 0; membus_rvalid = 1; // cycle 2: WAIT_RESP
        @(negedge clk); membus_rvalid = 0;                // cycle 3: done
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || rdata !== 64'h1) $display("FAIL b2b_first: got done=%b busy=%b rdata=%h expected 1 0 1", done, busy, rdata); else n_pass++;
        req_funct3 = 3'b010; req_addr = 64'h1004;
        @(negedge clk);                                   // cycle 4: retire slot
        n_checks++; if (membus_valid !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_gap: got valid=%b busy=%b expected 0 1", membus_valid, busy); else n_pass++;
        @(negedge clk); membus_ready = 1;                 // cycle 5: second ISSUE
        n_checks++; if (membus_valid !== 1'b1 || membus_addr !== 64'h1004) $display("FAIL b2b_second: got valid=%b addr=%h expected 1 1004", membus_valid, membus_addr); else n_pass++;
        @(negedge clk); membus_ready = 0; membus_rvalid = 1;
        @(negedge clk); membus_rvalid = 0; req_valid = 0;
        n_checks++; if (done !== 1'b1 || rdata !== 64'hFFFF_FFFF_89AB_CDEF) $display("FAIL b2b_second_done: got done=%b rdata=%h expected 1 ffffffff89abcdef", done, rdata); else n_pass++;
        $display("txn back-to-back LBU 1003 then LW 1004 -> rdata=%h", rdata);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int stray_done = 0;
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_funct3 = 3'b011; req_addr = 64'h4000; membus_rdata = RSP;
        @(negedge clk); membus_ready = 1;
        @(negedge clk); membus_ready = 0; req_valid = 0;  // now in WAIT_RESP
        rst = 0;
        #1;
        n_checks++; if (membus_valid !== 1'b0 || membus_addr !== 64'h0 || done !== 1'b0 || rdata !== 64'h0) $display("FAIL rstmid_outputs: got valid=%b addr=%h done=%b rdata=%h expected zeros", membus_valid, membus_addr, done, rdata); else n_pass++;
        @(negedge clk); rst = 1;
        @(negedge clk); membus_rvalid = 1;
        @(negedge clk); membus_rvalid = 0;
        if (done) stray_done++;
        @(negedge clk);
        if (done) stray_done++;
        n_checks++; if (stray_done !== 0) $display("FAIL rstmid_stray: got %0d done pulses expected 0", stray_done); else n_pass++;
        $display("txn reset during WAIT_RESP, stray rvalid -> done pulses %0d", stray_done);
        do_access(3'b011, 1'b0, 64'h4008, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 0);
        n_checks++; if (t_rdata !== 64'hCAFE_F00D_1234_5678 || t_done_cyc !== 3) $display("FAIL rstmid_ld: got %h@%0d expected cafef00d12345678@3", t_rdata, t_done_cyc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_store_sh();
        test_errors();
        test_stall();
        test_req_drop();
        test_stray_rvalid();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/membus_lsu.md
Name: membus_lsu

Overview:
- Load/store initiator for Membus: the requester end that drives valid/addr/wen/wdata/wmask and consumes ready/rvalid/rdata from memory-mapped responders (RAM, ACLINT, UART).
- Sits between the core's memory stage and the bus.
- Converts RV64 byte/half/word/double loads and stores into 64-bit lane-aligned bus transactions with byte masks.
- Extracts and sign- or zero-extends load data.
- Detects misaligned and illegal accesses.

Parameters:
- XLEN, 64, core register and address width.
- MEMBUS_DATA_WIDTH, 64, bus data width; wmask is MEMBUS_DATA_WIDTH/8 bits wide.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core requests an access; held until done or err.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (rs2), right-aligned.
- busy  out  1  core must stall.
- done  out  1  one-cycle pulse: access complete.
- rdata  out  XLEN  extended load result, valid when done && !req_wen.
- err  out  1  one-cycle pulse: misaligned or illegal access.
- membus_valid  out  1  bus request.
- membus_ready  in  1  responder accepts.
- membus_addr  out  XLEN  full byte address.
- membus_wen  out  1  write.
- membus_wdata  out  64  lane-shifted store data.
- membus_wmask  out  8  byte-enable mask.
- membus_rvalid  in  1  response strobe; exactly one per accepted request, reads and writes.
- membus_rdata  in  64  read data.

Behaviour:
- Reset values: state IDLE; membus_valid, membus_wen, done and err = 0; membus_addr, membus_wdata, membus_wmask and rdata = 0.
- State machine: IDLE -> ISSUE -> WAIT_RESP -> IDLE.
  - IDLE with req_valid and a legal access:
    - Latch addr, funct3, wen and shifted wdata/wmask into the membus_* registers.
    - Go to ISSUE.
  - ISSUE:
    - membus_valid = 1 and all membus_* outputs are held stable.
    - On membus_valid && membus_ready, go to WAIT_RESP and drop membus_valid the next cycle.
  - WAIT_RESP: on membus_rvalid, register the extended result into rdata, pulse done for one cycle and return to IDLE.
- busy = req_valid && !(done || err). After done or err, the FSM waits one IDLE cycle before accepting a new req_valid, so the core can retire the access.
- Latency with zero-wait responder (ready = 1, rvalid one cycle after acceptance):
  - req_valid at cycle 0.
  - membus_valid at cycle 1.
  - rvalid at cycle 2.
  - done at cycle 3.
- Lane rules, with off = req_addr[2:0]:
  - Size mask: B = 0x01, H = 0x03, W = 0x0F, D = 0xFF.
  - membus_wmask = size mask << off; 0 for loads.
  - membus_wdata = req_wdata << (8 * off).
- Load extraction:
  - s = membus_rdata >> (8 * off), then truncate to size.
  - B/H/W are sign-extended; BU/HU/WU are zero-extended; D is passed unchanged.
- Illegal or misaligned accesses: no bus transaction is issued; err pulses the cycle after req_valid is sampled in IDLE.
  - Misaligned: H with off[0] != 0, W with off[1:0] != 0, D with off != 0.
  - Illegal: funct3 = 111; stores with funct3 >= 100.
- membus_rvalid in IDLE or ISSUE is a protocol violation: ignored, and no done pulse.
- Reset mid-operation returns to IDLE immediately and drops membus_valid. Any later rvalid from the aborted access is ignored.
- A req_valid deassert while in ISSUE or WAIT_RESP does not abort; the transaction completes and done still pulses.

Test Plan:
- LW req_addr 0x1004, responder returns 0x89ABCDEF_01234567 -> membus_addr 0x1004, wmask 0x00, wen 0; rdata 0xFFFFFFFF_89ABCDEF; done at cycle 3.
- LBU at 0x1003 with the same rdata, then LB at 0x1007 -> rdata 0x00000000_00000001, then 0xFFFFFFFF_FFFFFF89.
- SH req_addr 0x2006, req_wdata 0xDEAD_1234 -> membus_wdata 0x1234_0000_0000_0000 (lower lanes zero), wmask 0xC0, wen 1; done after rvalid.
- LW at 0x1002, and SD at 0x2004 -> err pulse one cycle after request; membus_valid never asserted; done stays 0.
- SD 0x3000 with membus_ready held low 3 cycles -> membus_valid, addr, wdata and wmask stable across the stall; wmask 0xFF; exactly one acceptance; one done.
- Assert rst during WAIT_RESP, then drive a stray rvalid -> outputs return to reset values; no done pulse; the next LD completes normally.
